// File: rtl/scan_pkg.sv
// Shared types and default widths for the scan sequencer and its timing counters.
package scan_pkg;

    localparam int DWELL_W_DEF = 8;
    localparam int BLANK_W_DEF = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BLNK = 2'd1,
        ACT  = 2'd2
    } state_t;

    typedef logic [1:0] phase_t;

    localparam phase_t LAST_PHASE = 2'd3;

endpackage

// File: rtl/cycle_down_counter.sv
// Loadable down-counter that saturates at zero; zero flags the last cycle of an interval.
module cycle_down_counter #(
    parameter int W = 4
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] count_r;

    // Load wins over decrement; decrement stops at zero so all-ones loads count fully.
    always_ff @(posedge CLK) begin
        if (RST) begin
            count_r <= '0;
        end else if (load) begin
            count_r <= load_val;
        end else if (dec && (count_r != '0)) begin
            count_r <= count_r - {{(W-1){1'b0}}, 1'b1};
        end else begin
            count_r <= count_r;
        end
    end

    assign zero = (count_r == '0);

endmodule

// File: rtl/scan_sequencer.sv
// Four-phase scan sequencer: blanking then active dwell per phase, driving a 2-to-4 decoder.
module scan_sequencer
    import scan_pkg::*;
#(
    parameter int DWELL_W = DWELL_W_DEF,
    parameter int BLANK_W = BLANK_W_DEF
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               START,
    input  logic               STOP,
    input  logic               LOOP,
    input  logic [DWELL_W-1:0] DWELL,
    input  logic [BLANK_W-1:0] BLANK,
    output logic               A0,
    output logic               A1,
    output logic               EN,
    output logic               BUSY,
    output logic               DONE
);

    state_t             state_r;
    phase_t             phase_r;
    logic               en_r;
    logic               busy_r;
    logic               done_r;
    logic [DWELL_W-1:0] dwell_l_r;
    logic [BLANK_W-1:0] blank_l_r;
    logic               loop_r;

    logic               start_ok_s;
    logic               act_end_s;
    logic               continue_s;
    logic               blank_end_s;
    logic               blank_load_s;
    logic               dwell_load_s;
    logic [BLANK_W-1:0] blank_load_val_s;
    logic [DWELL_W-1:0] dwell_load_val_s;
    logic               blank_zero_s;
    logic               dwell_zero_s;

    // Counter load/decrement control: a counter is loaded on the edge that enters its state.
    always_comb begin
        start_ok_s   = (state_r == IDLE) && START && !STOP;
        act_end_s    = (state_r == ACT) && dwell_zero_s && !STOP;
        continue_s   = act_end_s && ((phase_r != LAST_PHASE) || loop_r);
        blank_end_s  = (state_r == BLNK) && blank_zero_s && !STOP;
        blank_load_s = (start_ok_s && (BLANK != '0)) || (continue_s && (blank_l_r != '0));
        dwell_load_s = (start_ok_s && (BLANK == '0)) || blank_end_s
                     || (continue_s && (blank_l_r == '0));
        if (state_r == IDLE) begin
            blank_load_val_s = BLANK - {{(BLANK_W-1){1'b0}}, 1'b1};
            dwell_load_val_s = DWELL;
        end else begin
            blank_load_val_s = blank_l_r - {{(BLANK_W-1){1'b0}}, 1'b1};
            dwell_load_val_s = dwell_l_r;
        end
    end

    cycle_down_counter #(.W(BLANK_W)) u_blank_cnt (
        .CLK      (CLK),
        .RST      (RST),
        .load     (blank_load_s),
        .load_val (blank_load_val_s),
        .dec      (state_r == BLNK),
        .zero     (blank_zero_s)
    );

    cycle_down_counter #(.W(DWELL_W)) u_dwell_cnt (
        .CLK      (CLK),
        .RST      (RST),
        .load     (dwell_load_s),
        .load_val (dwell_load_val_s),
        .dec      (state_r == ACT),
        .zero     (dwell_zero_s)
    );

    // Sequencer FSM with registered outputs; RST over STOP over everything else.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r   <= IDLE;
            phase_r   <= 2'd0;
            en_r      <= 1'b0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            dwell_l_r <= '0;
            blank_l_r <= '0;
            loop_r    <= 1'b0;
        end else if (STOP) begin
            state_r <= IDLE;
            phase_r <= 2'd0;
            en_r    <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    done_r  <= 1'b0;
                    phase_r <= 2'd0;
                    if (START) begin
                        dwell_l_r <= DWELL;
                        blank_l_r <= BLANK;
                        loop_r    <= LOOP;
                        busy_r    <= 1'b1;
                        if (BLANK != '0) begin
                            state_r <= BLNK;
                            en_r    <= 1'b0;
                        end else begin
                            state_r <= ACT;
                            en_r    <= 1'b1;
                        end
                    end else begin
                        state_r <= IDLE;
                        en_r    <= 1'b0;
                        busy_r  <= 1'b0;
                    end
                end
                BLNK: begin
                    done_r <= 1'b0;
                    if (blank_zero_s) begin
                        state_r <= ACT;
                        en_r    <= 1'b1;
                    end else begin
                        state_r <= BLNK;
                        en_r    <= 1'b0;
                    end
                end
                ACT: begin
                    if (dwell_zero_s) begin
                        done_r  <= (phase_r == LAST_PHASE);
                        phase_r <= phase_r + 2'd1;
                        if ((phase_r == LAST_PHASE) && !loop_r) begin
                            state_r <= IDLE;
                            en_r    <= 1'b0;
                            busy_r  <= 1'b0;
                        end else if (blank_l_r != '0) begin
                            state_r <= BLNK;
                            en_r    <= 1'b0;
                        end else begin
                            state_r <= ACT;
                            en_r    <= 1'b1;
                        end
                    end else begin
                        done_r <= 1'b0;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    phase_r <= 2'd0;
                    en_r    <= 1'b0;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                end
            endcase
        end
    end

    assign A0   = phase_r[0];
    assign A1   = phase_r[1];
    assign EN   = en_r;
    assign BUSY = busy_r;
    assign DONE = done_r;

endmodule

// File: tb/tb_scan_sequencer.sv
// Directed bench for scan_sequencer; outputs are checked as {DONE,BUSY,EN,A1,A0} one step after each edge.
module tb_scan_sequencer;

    logic       CLK = 1'b0;
    logic       RST;
    logic       START;
    logic       STOP;
    logic       LOOP;
    logic [7:0] DWELL;
    logic [3:0] BLANK;
    logic       A0, A1, EN, BUSY, DONE;

    int n_cmp = 0;
    int n_bad = 0;

    scan_sequencer dut (
        .CLK   (CLK),
        .RST   (RST),
        .START (START),
        .STOP  (STOP),
        .LOOP  (LOOP),
        .DWELL (DWELL),
        .BLANK (BLANK),
        .A0    (A0),
        .A1    (A1),
        .EN    (EN),
        .BUSY  (BUSY),
        .DONE  (DONE)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [4:0] exp);
        logic [4:0] obs;
        obs = {DONE, BUSY, EN, A1, A0};
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Checks n cycles of a non-looping sweep; at cycle poke_k settings change and START is re-asserted.
    task automatic run(input int d, input int b, input int n, input int poke_k, input string tag);
        int len;
        int ph;
        int w;
        logic [1:0] p;
        len = b + d + 1;
        for (int k = 1; k <= n; k++) begin
            tick();
            ph = ((k - 1) / len) % 4;
            w  = (k - 1) % len;
            p  = ph[1:0];
            chk($sformatf("%s_c%0d", tag, k), {1'b0, 1'b1, (w >= b), p});
            if (k == poke_k) begin
                DWELL = 8'd5;
                BLANK = 4'd0;
                LOOP  = 1'b1;
                START = 1'b1;
            end else begin
                START = 1'b0;
            end
        end
    endtask

    task automatic done_tail(input string tag);
        tick();
        chk({tag, "_done"}, 5'b10000);
        tick();
        chk({tag, "_idle"}, 5'b00000);
    endtask

    initial begin
        RST = 1'b1; START = 1'b0; STOP = 1'b0; LOOP = 1'b0;
        DWELL = 8'd0; BLANK = 4'd0;
        tick();
        tick();
        chk("reset", 5'b00000);

        START = 1'b1; DWELL = 8'd2; BLANK = 4'd1;
        tick();
        chk("rst_over_start", 5'b00000);

        // basic sweep, START on the first edge after reset release
        RST = 1'b0;
        run(2, 1, 16, 0, "basic");
        done_tail("basic");

        START = 1'b1; STOP = 1'b1;
        tick();
        chk("start_stop_idle", 5'b00000);
        START = 1'b0; STOP = 1'b0;
        tick();
        chk("start_stop_idle2", 5'b00000);

        // settings and START changed mid-sweep must not disturb it
        START = 1'b1; DWELL = 8'd2; BLANK = 4'd1; LOOP = 1'b0;
        run(2, 1, 16, 6, "midchg");
        done_tail("midchg");
        LOOP = 1'b0; START = 1'b1;
        run(5, 0, 24, 0, "newdwell");
        done_tail("newdwell");

        // zero extremes in loop mode
        START = 1'b1; DWELL = 8'd0; BLANK = 4'd0; LOOP = 1'b1;
        for (int k = 1; k <= 13; k++) begin
            int ph;
            logic [1:0] p;
            logic dn;
            tick();
            ph = (k - 1) % 4;
            p  = ph[1:0];
            dn = (k > 1) && (((k - 1) % 4) == 0);
            chk($sformatf("loop_c%0d", k), {dn, 1'b1, 1'b1, p});
            START = 1'b0;
        end
        STOP = 1'b1;
        tick();
        chk("loop_stop", 5'b00000);
        STOP = 1'b0;
        tick();
        chk("loop_stop_idle", 5'b00000);

        // STOP in phase 2 active
        START = 1'b1; DWELL = 8'd2; BLANK = 4'd1; LOOP = 1'b0;
        run(2, 1, 10, 0, "stop");
        STOP = 1'b1;
        tick();
        chk("stop_now", 5'b00000);
        STOP = 1'b0;
        for (int k = 0; k < 20; k++) begin
            tick();
            chk($sformatf("stop_nodone_%0d", k), 5'b00000);
        end

        // RST in phase 1 active
        START = 1'b1;
        run(2, 1, 7, 0, "rstmid");
        RST = 1'b1;
        tick();
        chk("rstmid_reset", 5'b00000);
        RST = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk($sformatf("rstmid_idle_%0d", k), 5'b00000);
        end
        START = 1'b1;
        run(2, 1, 16, 0, "rstmid_again");
        done_tail("rstmid_again");

        // all-ones extremes
        START = 1'b1; DWELL = 8'd255; BLANK = 4'd15; LOOP = 1'b0;
        run(255, 15, 1084, 0, "max");
        done_tail("max");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
